// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode definitions for the datapath ALU and its checkers
// Contents: ALUOP_W opcode width and OP_* opcode encodings.
package alu_pkg;

    localparam int ALUOP_W = 3;

    localparam logic [ALUOP_W-1:0] OP_PASS = 3'd0;
    localparam logic [ALUOP_W-1:0] OP_NOT  = 3'd1;
    localparam logic [ALUOP_W-1:0] OP_ADD  = 3'd2;
    localparam logic [ALUOP_W-1:0] OP_SUB  = 3'd3;
    localparam logic [ALUOP_W-1:0] OP_OR   = 3'd4;
    localparam logic [ALUOP_W-1:0] OP_AND  = 3'd5;
    localparam logic [ALUOP_W-1:0] OP_SLT  = 3'd6;
    localparam logic [ALUOP_W-1:0] OP_SLTU = 3'd7;

endpackage

// File: rtl/alu_ideal.sv
// rtl/alu_ideal.sv - combinational golden ALU used as the reference model
// Ports:
//   alu_op  in  ALUOP_W    opcode
//   r2, r3  in  WORD_SIZE  operands
//   result  out WORD_SIZE  ideal result, truncated to WORD_SIZE
module alu_ideal
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [ALUOP_W-1:0]   alu_op,
    input  logic [WORD_SIZE-1:0] r2,
    input  logic [WORD_SIZE-1:0] r3,
    output logic [WORD_SIZE-1:0] result
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(r2) < $signed(r3);
    assign lt_unsigned = r2 < r3;

    always_comb begin
        result = '0;
        case (alu_op)
            OP_PASS: result = r2;
            OP_NOT:  result = ~r2;
            OP_ADD:  result = r2 + r3;
            OP_SUB:  result = r2 - r3;
            OP_OR:   result = r2 | r3;
            OP_AND:  result = r2 & r3;
            OP_SLT:  result = {{(WORD_SIZE-1){1'b0}}, lt_signed};
            OP_SLTU: result = {{(WORD_SIZE-1){1'b0}}, lt_unsigned};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_check_queue.sv
// rtl/alu_check_queue.sv - scoreboard comparing ALU-under-test results against a golden ALU
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   clear                      synchronous flush of queue, counters, flags, capture
//   in_valid, alu_op, r2, r3   issued operation
//   dut_valid, dut_result      result returned by the ALU under test
//   chk_valid, error_bits, error_flag, expected_out   per-comparison report
//   err_count                  saturating failure count
//   first_err_valid/op/bits    first failure capture
//   overflow, underflow        sticky queue misuse flags
//   level                      expected-queue occupancy
module alu_check_queue
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [ALUOP_W-1:0]         alu_op,
    input  logic [WORD_SIZE-1:0]       r2,
    input  logic [WORD_SIZE-1:0]       r3,
    input  logic                       dut_valid,
    input  logic [WORD_SIZE-1:0]       dut_result,
    output logic                       chk_valid,
    output logic [WORD_SIZE-1:0]       error_bits,
    output logic                       error_flag,
    output logic [WORD_SIZE-1:0]       expected_out,
    output logic [CNT_W-1:0]           err_count,
    output logic                       first_err_valid,
    output logic [ALUOP_W-1:0]         first_err_op,
    output logic [WORD_SIZE-1:0]       first_err_bits,
    output logic                       overflow,
    output logic                       underflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef struct packed {
        logic [ALUOP_W-1:0]   op;
        logic [WORD_SIZE-1:0] val;
    } entry_t;

    entry_t               mem [DEPTH];
    entry_t               head;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [WORD_SIZE-1:0] golden;
    logic [WORD_SIZE-1:0] cmp_bits;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 cmp_fail;

    alu_ideal #(.WORD_SIZE(WORD_SIZE)) u_ideal (
        .alu_op (alu_op),
        .r2     (r2),
        .r3     (r3),
        .result (golden)
    );

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    // Popping frees the head slot this cycle, so a full queue can still accept.
    assign pop   = dut_valid && !empty;
    assign push  = in_valid && (!full || pop);
    assign drop  = in_valid && full && !pop;

    assign head     = mem[rd_ptr];
    assign cmp_bits = head.val ^ dut_result;
    assign cmp_fail = pop && (|cmp_bits);

    assign error_flag = chk_valid && (|error_bits);

    // Queue storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= '{op: alu_op, val: golden};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            chk_valid       <= 1'b0;
            error_bits      <= '0;
            expected_out    <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_op    <= '0;
            first_err_bits  <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else if (clear) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            chk_valid       <= 1'b0;
            error_bits      <= '0;
            expected_out    <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_op    <= '0;
            first_err_bits  <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            chk_valid <= pop;
            if (pop) begin
                error_bits   <= cmp_bits;
                expected_out <= head.val;
                rd_ptr       <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (dut_valid && empty) begin
                underflow <= 1'b1;
            end
            if (cmp_fail) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_op    <= head.op;
                    first_err_bits  <= cmp_bits;
                end
            end
        end
    end

endmodule
